// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, FSM state encoding and small decode helpers for the
// iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

  function automatic logic is_iter_op(input logic [2:0] o);
    return (o == MDU_MULT) || (o == MDU_MULTU) || (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_iter_step.sv
// One iteration of the MDU datapath: shift-add for multiply, restoring
// shift-subtract for divide. {acc_hi, acc_lo} is the 2*WIDTH working register.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;

  always_comb begin
    add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    trial     = rem_shift - {1'b0, operand};
    if (is_div) begin
      // Bit WIDTH of the trial difference is the borrow: set means restore.
      if (!trial[WIDTH]) begin
        hi_next = trial[WIDTH-1:0];
        lo_next = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rem_shift[WIDTH-1:0];
        lo_next = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = add_sum[WIDTH:1];
      lo_next = {add_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers. Works on
// operand magnitudes and applies the sign correction in a final FIX cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] acc_hi_reg, acc_hi_next;
  logic [WIDTH-1:0] acc_lo_reg, acc_lo_next;
  logic [WIDTH-1:0] opnd_reg, opnd_next;
  logic [WIDTH-1:0] orig_a_reg, orig_a_next;
  logic             is_div_reg, is_div_next;
  logic             neg_lo_reg, neg_lo_next;
  logic             neg_hi_reg, neg_hi_next;
  logic             div_zero_reg, div_zero_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             done_reg, done_next;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_reg),
    .acc_hi  (acc_hi_reg),
    .acc_lo  (acc_lo_reg),
    .operand (opnd_reg),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_comb begin
    sign_a   = is_signed_op(op) & a[WIDTH-1];
    sign_b   = is_signed_op(op) & b[WIDTH-1];
    mag_a    = sign_a ? (~a + 1'b1) : a;
    mag_b    = sign_b ? (~b + 1'b1) : b;
    prod_fix = neg_lo_reg ? (~{acc_hi_reg, acc_lo_reg} + 1'b1) : {acc_hi_reg, acc_lo_reg};
    quot_fix = neg_lo_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
    rem_fix  = neg_hi_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    acc_hi_next   = acc_hi_reg;
    acc_lo_next   = acc_lo_reg;
    opnd_next     = opnd_reg;
    orig_a_next   = orig_a_reg;
    is_div_next   = is_div_reg;
    neg_lo_next   = neg_lo_reg;
    neg_hi_next   = neg_hi_reg;
    div_zero_next = div_zero_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    done_next     = 1'b0;
    case (state_reg)
      MDU_IDLE: begin
        // A cancel on the issue edge drops the request, MTHI/MTLO included.
        if (start && !cancel) begin
          if (is_iter_op(op)) begin
            state_next    = MDU_RUN;
            cnt_next      = '0;
            is_div_next   = is_div_op(op);
            neg_lo_next   = sign_a ^ sign_b;
            neg_hi_next   = sign_a;
            div_zero_next = (b == '0);
            orig_a_next   = a;
            acc_hi_next   = '0;
            acc_lo_next   = is_div_op(op) ? mag_a : mag_b;
            opnd_next     = is_div_op(op) ? mag_b : mag_a;
          end else if (op == MDU_MTHI) begin
            hi_next = a;
          end else if (op == MDU_MTLO) begin
            lo_next = a;
          end
        end
      end
      MDU_RUN: begin
        if (cancel) begin
          state_next = MDU_IDLE;
        end else begin
          acc_hi_next = step_hi;
          acc_lo_next = step_lo;
          cnt_next    = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_next = MDU_FIX;
          end
        end
      end
      MDU_FIX: begin
        state_next = MDU_IDLE;
        if (!cancel) begin
          done_next = 1'b1;
          if (!is_div_reg) begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
          end else if (div_zero_reg) begin
            hi_next = orig_a_reg;
            lo_next = '1;
          end else begin
            hi_next = rem_fix;
            lo_next = quot_fix;
          end
        end
      end
      default: state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= MDU_IDLE;
      cnt_reg      <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      opnd_reg     <= '0;
      orig_a_reg   <= '0;
      is_div_reg   <= 1'b0;
      neg_lo_reg   <= 1'b0;
      neg_hi_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      acc_hi_reg   <= acc_hi_next;
      acc_lo_reg   <= acc_lo_next;
      opnd_reg     <= opnd_next;
      orig_a_reg   <= orig_a_next;
      is_div_reg   <= is_div_next;
      neg_lo_reg   <= neg_lo_next;
      neg_hi_reg   <= neg_hi_next;
      div_zero_reg <= div_zero_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      done_reg     <= done_next;
    end
  end

  assign busy = (state_reg != MDU_IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases followed by
// random operations scored against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cancel = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  task automatic ref_mdu(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint p, sx, sy, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = '0;
    rl = '0;
    case (o)
      3'd0: begin p = sx * sy; u = p; rh = u[63:32]; rl = u[31:0]; end
      3'd1: begin u = {32'b0, x} * {32'b0, y}; rh = u[63:32]; rl = u[31:0]; end
      3'd2, 3'd3: begin
        if (y == '0) begin
          rh = x;
          rl = '1;
        end else if (o == 3'd2) begin
          q = sx / sy;
          r = sx % sy;
          u = q; rl = u[31:0];
          u = r; rh = u[31:0];
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
      default: ;
    endcase
  endtask

  // Issue an iterative op; optionally cancel or inject a stray start at a
  // given cycle index (the value driven at negedge c is sampled at edge E_c).
  task automatic run_mdu(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int cancel_at, input int inject_at);
    int done_cnt, done_cyc, busy_cnt;
    logic [W-1:0] eh, el;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    if (cancel_at > 0) begin
      eh = m_hi; el = m_lo;
    end else begin
      ref_mdu(o, x, y, eh, el);
    end
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    for (int c = 1; c <= W + 4; c++) begin
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = c; end
      if (c == inject_at) begin
        start = 1'b1; op = 3'($urandom_range(0, 5)); a = $urandom; b = $urandom;
      end
      if (c == cancel_at) cancel = 1'b1;
    end
    start = 1'b0; cancel = 1'b0;
    check({tag, ".hi"}, 64'(hi), 64'(eh));
    check({tag, ".lo"}, 64'(lo), 64'(el));
    check({tag, ".busy_end"}, 64'(busy), 64'(0));
    if (cancel_at > 0) begin
      check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(cancel_at));
      check({tag, ".done_count"}, 64'(done_cnt), 64'(0));
    end else begin
      check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
      check({tag, ".done_count"}, 64'(done_cnt), 64'(1));
      check({tag, ".done_cycle"}, 64'(done_cyc), 64'(W + 2));
    end
    m_hi = eh; m_lo = el;
    $display("op=%0d a=%h b=%h cancel_at=%0d inject_at=%0d -> hi=%h lo=%h", o, x, y,
             cancel_at, inject_at, hi, lo);
  endtask

  task automatic do_mt(input string tag, input logic [2:0] o, input logic [W-1:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(negedge clk);
    start = 1'b0;
    if (o == 3'd4) m_hi = x; else m_lo = x;
    check({tag, ".hi"}, 64'(hi), 64'(m_hi));
    check({tag, ".lo"}, 64'(lo), 64'(m_lo));
    check({tag, ".busy"}, 64'(busy), 64'(0));
    check({tag, ".done"}, 64'(done), 64'(0));
    $display("op=%0d a=%h -> hi=%h lo=%h", o, x, hi, lo);
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    int           rc, ri;

    repeat (3) @(negedge clk);
    check("reset.hi", 64'(hi), 64'(0));
    check("reset.lo", 64'(lo), 64'(0));
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    rst = 1'b0;

    run_mdu("mult_neg", 3'd0, 32'hFFFFFFFD, 32'h00000005, 0, 0);
    check("mult_neg.hi_const", 64'(hi), 64'h00000000FFFFFFFF);
    check("mult_neg.lo_const", 64'(lo), 64'h00000000FFFFFFF1);
    run_mdu("multu_ones", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 7);
    check("multu_ones.hi_const", 64'(hi), 64'h00000000FFFFFFFE);
    check("multu_ones.lo_const", 64'(lo), 64'h0000000000000001);
    run_mdu("div_neg", 3'd2, 32'hFFFFFFF9, 32'h00000002, 0, 0);
    check("div_neg.lo_const", 64'(lo), 64'h00000000FFFFFFFD);
    check("div_neg.hi_const", 64'(hi), 64'h00000000FFFFFFFF);
    run_mdu("div_min", 3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div_min.lo_const", 64'(lo), 64'h0000000080000000);
    check("div_min.hi_const", 64'(hi), 64'h0000000000000000);
    run_mdu("divu_zero", 3'd3, 32'h00000007, 32'h00000000, 0, 0);
    check("divu_zero.lo_const", 64'(lo), 64'h00000000FFFFFFFF);
    check("divu_zero.hi_const", 64'(hi), 64'h0000000000000007);
    run_mdu("div_zero", 3'd2, 32'hFFFFFF00, 32'h00000000, 0, 0);

    // MTHI then MTLO on consecutive edges.
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h12345678;
    @(negedge clk);
    op = 3'd5; a = 32'h9ABCDEF0;
    check("mthi.hi", 64'(hi), 64'h0000000012345678);
    check("mthi.busy", 64'(busy), 64'(0));
    check("mthi.done", 64'(done), 64'(0));
    @(negedge clk);
    start = 1'b0;
    check("mtlo.lo", 64'(lo), 64'h000000009ABCDEF0);
    check("mtlo.hi", 64'(hi), 64'h0000000012345678);
    check("mtlo.busy", 64'(busy), 64'(0));
    check("mtlo.done", 64'(done), 64'(0));
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
    $display("op=4/5 back-to-back -> hi=%h lo=%h", hi, lo);

    run_mdu("mult_cancel", 3'd0, 32'h00001234, 32'h00005678, 10, 0);
    run_mdu("div_cancel_fix", 3'd3, 32'h00000100, 32'h00000003, W + 1, 0);

    // Cancel on the same edge as an idle start drops the request.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start.hi", 64'(hi), 64'(m_hi));
    check("cancel_start.busy", 64'(busy), 64'(0));

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'h00ABCDEF; b = 32'h00000013;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.hi", 64'(hi), 64'(0));
    check("midrst.lo", 64'(lo), 64'(0));
    check("midrst.busy", 64'(busy), 64'(0));
    check("midrst.done", 64'(done), 64'(0));
    m_hi = '0; m_lo = '0;
    $display("reset mid-DIV -> hi=%h lo=%h busy=%0d", hi, lo, busy);
    run_mdu("after_rst", 3'd2, 32'h00ABCDEF, 32'h00000013, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 255));
      if (ro >= 3'd4) begin
        do_mt("rand_mt", ro, ra);
      end else begin
        rc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W + 1)) : 0;
        ri = (rc == 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, W + 1)) : 0;
        run_mdu("rand_op", ro, ra, rb, rc, ri);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit for the MIPS EXE stage, alongside the combinational ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and owns the architectural HI/LO registers, including MTHI/MTLO writes.
- Width is parametrised.
- Asserts busy so the pipeline controller can stall MFHI/MFLO and further mult/div issue.
- Accepts a cancel from the interrupt/exception logic to flush an in-flight operation.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  issue request, sampled each rising edge
- op  in  3  MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5; 6/7 reserved
- a  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
- b  in  WIDTH  rt operand (multiplier/divisor)
- cancel  in  1  flush in-flight operation (exception/interrupt)
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. rst overrides start and cancel, including mid-operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - On start with op 0-3 at edge E0: latch |a|,|b| (magnitudes for signed ops), result signs, and op. Counter=0. Go to RUN. busy=1 from E0.
  - On start with MTHI/MTLO at E0: write hi (resp. lo) from a at that edge. No busy, no done.
  - Reserved op: ignored.
- RUN: edges E1..E_WIDTH, one iteration per edge.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing one quotient bit per edge.
  - After E_WIDTH go to FIX.
- FIX: at edge E_(WIDTH+1):
  - Apply sign correction.
  - Write {hi,lo}: product, or hi=remainder and lo=quotient.
  - done=1 for exactly the following cycle; busy=0; state=IDLE.
  - Total latency: WIDTH+1 edges after the start edge (33 at WIDTH=32).
- Signed rules:
  - Product is negated when a and b signs differ.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign follows the dividend.
  - Truncation toward zero.
- Boundary cases:
  - Divide by zero, signed or unsigned: full latency, lo=all ones, hi=a (original value), done pulses.
  - DIV MIN/-1: lo=MIN (wraps), hi=0. No trap.
  - MULTU of all-ones by all-ones: hi = all ones minus 1, lo=1.
- start while busy=1: ignored, including MTHI/MTLO. The controller must stall; the unit does not queue.
- cancel:
  - In RUN or FIX: return to IDLE at that edge; hi/lo unchanged; no done; busy=0 next cycle.
  - Same edge as an IDLE start: cancel wins and the start is dropped.
  - In IDLE with no start: no effect.
- hi/lo change only on reset, an MTHI/MTLO edge, or a FIX edge.

Decomposition:
- Shared constants go in mips_define.vh as localparams: MDU_* op codes and MDU_IDLE/RUN/FIX state encodings.
- One sub-module is natural: mdu_iter_step.
  - Combinational single-iteration datapath: add-or-pass for multiply, trial subtract and quotient bit for divide.
  - Width-parametrised; instantiated once.
- The FSM, counter, sign handling and HI/LO registers stay in mult_div_unit.

Test Plan (WIDTH=32):
- MULT a=FFFFFFFD (-3), b=5 -> busy for 33 cycles; then done, hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; a second start during busy is ignored and hi/lo are unaffected.
- DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- DIVU a=7, b=0 -> after 33 cycles lo=FFFFFFFF, hi=00000007, done pulses once.
- MTHI a=12345678, then MTLO a=9ABCDEF0 on consecutive cycles -> hi/lo updated at each edge, busy/done never assert. Then MULT with cancel at iteration 10 -> hi/lo still 12345678/9ABCDEF0, no done, busy drops.
- rst asserted mid-DIV -> next cycle hi=lo=0, busy=0, done=0. A start on the following cycle runs normally.
